// File: rtl/ex_div_pkg.sv
// ex_div_pkg -- shared definitions for the EX-stage divider.
//
// Holds the divide op codes recognised on ex_aluop, the divider FSM state
// encoding, ZeroWord, and small helpers for classifying ops and taking
// operand magnitudes. Imported by ex_div and by its testbench.
package ex_div_pkg;

    localparam logic [7:0]  EXE_DIV   = 8'b0001_1010;
    localparam logic [7:0]  EXE_DIVU  = 8'b0001_1011;
    localparam logic [7:0]  EXE_REM   = 8'b0001_1110;
    localparam logic [7:0]  EXE_REMU  = 8'b0001_1111;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Number of radix-2 restoring iterations for a 32-bit divide.
    localparam int          DIV_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV) || (op == EXE_DIVU) ||
               (op == EXE_REM) || (op == EXE_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_DIV) || (op == EXE_REM);
    endfunction

    function automatic logic is_rem_op(input logic [7:0] op);
        return (op == EXE_REM) || (op == EXE_REMU);
    endfunction

    // Two's-complement magnitude for signed ops; unsigned ops pass through.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v,
                                              input logic        signed_op);
        return (signed_op && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// ex_div -- multi-cycle 32-bit divider for the EX stage.
//
// A divide op seen in IDLE (cycle T0) captures operands, destination and op,
// and holds the pipeline through stallreq. The normal path runs 32 restoring
// iterations in CALC (T1..T32) and presents the result in DONE (T33) for one
// cycle. Divide-by-zero and signed overflow skip CALC and finish at T1.
//
// Configuration macro: DIV_EARLY_EXIT_EN -- when defined, a divide whose
// dividend magnitude is below the (non-zero) divisor magnitude also finishes
// at T1 with quotient 0 and remainder = dividend.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ex_aluop   EX-stage op code (DIV/DIVU/REM/REMU start a divide)
//   ex_reg1    dividend
//   ex_reg2    divisor
//   ex_wd      destination register address
//   ex_wreg    destination write enable
//   annul      flush; aborts any operation in progress
//   stallreq   hold IF/ID/EX pipeline registers
//   div_valid  one-cycle result strobe
//   div_wdata  quotient or remainder (0 when div_valid=0)
//   div_wd     destination address captured at start (0 when div_valid=0)
//   div_wreg   write enable captured at start (0 when div_valid=0)
module ex_div
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic        annul,
    output logic        stallreq,
    output logic        div_valid,
    output logic [31:0] div_wdata,
    output logic [4:0]  div_wd,
    output logic        div_wreg
);

    div_state_e  state_reg, state_next;
    logic [31:0] quo_reg;       // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_reg;       // partial remainder
    logic [31:0] dsor_reg;      // divisor magnitude
    logic [4:0]  cnt_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        rem_sel_reg;
    logic [4:0]  wd_reg;
    logic        wreg_reg;

    logic        start;
    logic        signed_op;
    logic [31:0] mag1, mag2;
    logic        div_zero, signed_ovf, early, shortcut;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;
    logic [31:0] rem_step, quo_step;
    logic [31:0] quo_out, rem_out;

    assign start      = ~rst & ~annul & (state_reg == IDLE) & is_div_op(ex_aluop);
    assign signed_op  = is_signed_op(ex_aluop);
    assign mag1       = magnitude(ex_reg1, signed_op);
    assign mag2       = magnitude(ex_reg2, signed_op);
    assign div_zero   = (ex_reg2 == ZeroWord);
    assign signed_ovf = signed_op && (ex_reg1 == 32'h8000_0000) && (ex_reg2 == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_EXIT_EN
    assign early      = ~div_zero & (mag1 < mag2);
`else
    assign early      = 1'b0;
`endif

    // Cases whose results are known at T0 go straight to DONE.
    assign shortcut   = div_zero | signed_ovf | early;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. When it fits the true
    // difference is below the divisor, so 32-bit modular subtraction suffices.
    assign shifted    = {rem_reg, quo_reg[31]};
    assign fits       = shifted >= {1'b0, dsor_reg};
    assign diff       = shifted[31:0] - dsor_reg;
    assign rem_step   = fits ? diff : shifted[31:0];
    assign quo_step   = {quo_reg[30:0], fits};

    assign quo_out    = neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
    assign rem_out    = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = shortcut ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == 5'(DIV_STEPS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (annul) begin
            state_next = IDLE;
        end
    end

    // Outputs are gated by rst as well so they drop in the same cycle reset
    // asserts, even while a start condition is present on the inputs.
    always_comb begin
        stallreq  = 1'b0;
        div_valid = 1'b0;
        div_wdata = ZeroWord;
        div_wd    = 5'd0;
        div_wreg  = 1'b0;
        if (!rst && !annul) begin
            if (start || state_reg == CALC) begin
                stallreq = 1'b1;
            end
            if (state_reg == DONE) begin
                div_valid = 1'b1;
                div_wdata = rem_sel_reg ? rem_out : quo_out;
                div_wd    = wd_reg;
                div_wreg  = wreg_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_reg     <= ZeroWord;
            rem_reg     <= ZeroWord;
            dsor_reg    <= ZeroWord;
            cnt_reg     <= 5'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rem_sel_reg <= 1'b0;
            wd_reg      <= 5'd0;
            wreg_reg    <= 1'b0;
        end else if (start) begin
            rem_sel_reg <= is_rem_op(ex_aluop);
            wd_reg      <= ex_wd;
            wreg_reg    <= ex_wreg;
            cnt_reg     <= 5'd0;
            dsor_reg    <= mag2;
            if (shortcut) begin
                // Final values are loaded directly; no sign correction.
                quo_reg   <= div_zero ? 32'hFFFF_FFFF :
                             (signed_ovf ? 32'h8000_0000 : ZeroWord);
                rem_reg   <= signed_ovf ? ZeroWord : ex_reg1;
                neg_q_reg <= 1'b0;
                neg_r_reg <= 1'b0;
            end else begin
                quo_reg   <= mag1;
                rem_reg   <= ZeroWord;
                neg_q_reg <= signed_op & (ex_reg1[31] ^ ex_reg2[31]);
                neg_r_reg <= signed_op & ex_reg1[31];
            end
        end else if (state_reg == CALC) begin
            quo_reg <= quo_step;
            rem_reg <= rem_step;
            cnt_reg <= cnt_reg + 5'd1;
        end
    end

endmodule
